// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: sample format and the bit-to-sign mapping used by
// both the modulator and the demodulator.
package qpsk_pkg;

    localparam int unsigned QPSK_DATA_WIDTH = 12;

    // Bit 0 is sent as positive amplitude, bit 1 as negative amplitude.
    localparam logic QPSK_BIT0_POS = 1'b1;

    typedef logic signed [QPSK_DATA_WIDTH-1:0] qpsk_sample_t;

    // Map the sign of an integrated symbol to a hard bit; a zero sum decides bit 0.
    function automatic logic qpsk_slice(input logic is_neg);
        return QPSK_BIT0_POS ? is_neg : !is_neg;
    endfunction

endpackage

// File: rtl/qpsk_int_dump.sv
// Integrate-and-dump for one rail: accumulates samples over a symbol and
// registers the hard sign decision when the last sample arrives.
module qpsk_int_dump
    import qpsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = QPSK_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = QPSK_DATA_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic                  decision,
    output logic                  dump
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        dec_q, dec_d;

    always_comb begin
        sample_ext = {{(ACC_WIDTH - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
        // A load starts a fresh symbol, so the old partial sum is ignored.
        base       = load ? '0 : acc_q;
        sum        = base + sample_ext;
        acc_d      = acc_q;
        dec_d      = dec_q;
        if (en) begin
            if (last) begin
                acc_d = '0;
                dec_d = qpsk_slice(sum[ACC_WIDTH-1]);
            end else begin
                acc_d = sum;
            end
        end else if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            dec_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dec_q <= dec_d;
        end
    end

    assign decision = dec_q;
    assign dump     = en && last;

endmodule

// File: rtl/qpsk_demod.sv
// Hard-decision QPSK demodulator: per-rail integrate-and-dump over SPS samples
// with valid/ready handshakes on the sample and bit-pair interfaces.
module qpsk_demod
    import qpsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = QPSK_DATA_WIDTH,
    parameter int unsigned SPS        = 4,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + $clog2(SPS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_I,
    input  logic [DATA_WIDTH-1:0] i_Q,
    input  logic                  i_valid,
    input  logic                  i_sync,
    output logic                  o_ready,
    output logic                  o_I,
    output logic                  o_Q,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int unsigned    CntW   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SPS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            o_valid_q, o_valid_d;
    logic            accept;
    logic            last;
    logic            load;
    logic            clear;
    logic            dump_i, dump_q;
    logic            dump;

    assign o_ready = !o_valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign load    = accept && i_sync;
    // Sync outside an accepted beat only realigns when the source is idle.
    assign clear   = i_sync && !i_valid;
    assign last    = i_sync ? (SPS == 1) : (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (i_sync) begin
                cnt_d = (SPS == 1) ? '0 : CntW'(1);
            end else if (cnt_q == CntMax) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clear) begin
            cnt_d = '0;
        end
    end

    assign dump = dump_i && dump_q;

    always_comb begin
        o_valid_d = o_valid_q;
        if (dump) begin
            o_valid_d = 1'b1;
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;

    qpsk_int_dump #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_rail_i (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .load     (load),
        .clear    (clear),
        .last     (last),
        .sample   (i_I),
        .decision (o_I),
        .dump     (dump_i)
    );

    qpsk_int_dump #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_rail_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .load     (load),
        .clear    (clear),
        .last     (last),
        .sample   (i_Q),
        .decision (o_Q),
        .dump     (dump_q)
    );

endmodule

// File: tb/tb_qpsk_demod.sv
// Directed bench for qpsk_demod (SPS=4, 12-bit samples).
module tb_qpsk_demod;
    import qpsk_pkg::*;

    logic         clk;
    logic         rst_n;
    qpsk_sample_t si, sq;
    logic         i_valid, i_sync, i_ready;
    logic         o_ready, o_I, o_Q, o_valid;

    int checks   = 0;
    int failures = 0;

    bit got_i[$];
    bit got_q[$];

    qpsk_demod dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_I     (si),
        .i_Q     (sq),
        .i_valid (i_valid),
        .i_sync  (i_sync),
        .o_ready (o_ready),
        .o_I     (o_I),
        .o_Q     (o_Q),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every bit pair handed to the sink.
    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            got_i.push_back(o_I);
            got_q.push_back(o_Q);
        end
    end

    task automatic send(input int vi, input int vq, input logic sy);
        si      = qpsk_sample_t'(vi);
        sq      = qpsk_sample_t'(vq);
        i_sync  = sy;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sync  = 1'b0;
        i_ready = 1'b0;
        si      = '0;
        sq      = '0;
        #12;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid);
        end
        checks++;
        if ({o_I, o_Q} !== 2'b00) begin
            failures++; $display("FAIL reset_bits got=%b%b exp=00", o_I, o_Q);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset got ready=%b valid=%b exp 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_nominal();
        i_ready = 1'b1;
        got_i.delete(); got_q.delete();
        for (int s = 0; s < 3; s++) send(1000, -1000, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL nom_early_valid got=%b exp=0", o_valid);
        end
        send(1000, -1000, 1'b0);
        checks++;
        if ({o_valid, o_I, o_Q} !== 3'b101) begin
            failures++; $display("FAIL nom_sym0 got v/I/Q=%b%b%b exp=101", o_valid, o_I, o_Q);
        end
        for (int s = 0; s < 4; s++) send(-1000, 1000, 1'b0);
        checks++;
        if ({o_valid, o_I, o_Q} !== 3'b110) begin
            failures++; $display("FAIL nom_sym1 got v/I/Q=%b%b%b exp=110", o_valid, o_I, o_Q);
        end
        idle(2);
        checks++;
        if (got_i.size() !== 2 || {got_i[0], got_q[0], got_i[1], got_q[1]} !== 4'b0110) begin
            failures++;
            $display("FAIL nom_stream got n=%0d pairs=%b%b,%b%b exp n=2 pairs=01,10",
                     got_i.size(), got_i[0], got_q[0], got_i[1], got_q[1]);
        end
    endtask

    task automatic test_zero_extreme();
        i_ready = 1'b1;
        send(5, -2048, 1'b0);
        send(-5, -2048, 1'b0);
        send(3, -2048, 1'b0);
        send(-3, -2048, 1'b0);
        checks++;
        if ({o_valid, o_I} !== 2'b10) begin
            failures++; $display("FAIL zero_sum got v/I=%b%b exp=10", o_valid, o_I);
        end
        checks++;
        if (o_Q !== 1'b1) begin
            failures++; $display("FAIL extreme_neg got Q=%b exp=1", o_Q);
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        got_i.delete(); got_q.delete();
        for (int s = 0; s < 4; s++) send(1000, -1000, 1'b0);
        // Offer samples that would corrupt the next symbol if accepted.
        si      = qpsk_sample_t'(2000);
        sq      = qpsk_sample_t'(2000);
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({o_valid, o_I, o_Q, o_ready} !== 4'b1010) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v/I/Q/rdy=%b%b%b%b exp=1010",
                         c, o_valid, o_I, o_Q, o_ready);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int s = 0; s < 4; s++) send(-1000, 1000, 1'b0);
        checks++;
        if ({o_valid, o_I, o_Q} !== 3'b110) begin
            failures++; $display("FAIL bp_next got v/I/Q=%b%b%b exp=110", o_valid, o_I, o_Q);
        end
        idle(2);
        checks++;
        if (got_i.size() !== 2 || {got_i[0], got_q[0], got_i[1], got_q[1]} !== 4'b0110) begin
            failures++;
            $display("FAIL bp_stream got n=%0d pairs=%b%b,%b%b exp n=2 pairs=01,10",
                     got_i.size(), got_i[0], got_q[0], got_i[1], got_q[1]);
        end
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drain got v=%b exp=0", o_valid);
        end
    endtask

    task automatic test_sync();
        i_ready = 1'b1;
        got_i.delete(); got_q.delete();
        send(1000, 1000, 1'b0);
        send(1000, 1000, 1'b0);
        send(-1000, -1000, 1'b1);
        for (int s = 0; s < 3; s++) send(-1000, -1000, 1'b0);
        checks++;
        if ({o_valid, o_I, o_Q} !== 3'b111) begin
            failures++; $display("FAIL sync_decide got v/I/Q=%b%b%b exp=111", o_valid, o_I, o_Q);
        end
        idle(3);
        checks++;
        if (got_i.size() !== 1 || {got_i[0], got_q[0]} !== 2'b11) begin
            failures++;
            $display("FAIL sync_stream got n=%0d pair=%b%b exp n=1 pair=11",
                     got_i.size(), got_i[0], got_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        // Pending output must be dropped by reset.
        i_ready = 1'b0;
        for (int s = 0; s < 4; s++) send(1000, 1000, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++; $display("FAIL rst_pending got v=%b rdy=%b exp 0/1", o_valid, o_ready);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Partial symbol must be discarded by reset.
        i_ready = 1'b1;
        got_i.delete(); got_q.delete();
        send(-2000, -2000, 1'b0);
        send(-2000, -2000, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL rst_partial got v=%b exp=0", o_valid);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) send(1000, 1000, 1'b0);
        checks++;
        if ({o_valid, o_I, o_Q} !== 3'b100) begin
            failures++; $display("FAIL rst_decide got v/I/Q=%b%b%b exp=100", o_valid, o_I, o_Q);
        end
        idle(2);
        checks++;
        if (got_i.size() !== 1 || {got_i[0], got_q[0]} !== 2'b00) begin
            failures++;
            $display("FAIL rst_stream got n=%0d pair=%b%b exp n=1 pair=00",
                     got_i.size(), got_i[0], got_q[0]);
        end
    endtask

    task automatic test_loopback();
        logic [15:0] pat;
        logic        bi, bq;
        pat     = 16'b1110100101111000;
        i_ready = 1'b1;
        got_i.delete(); got_q.delete();
        // Modulator model: pairs LSB first, I = even bit, bit 0 -> +A, bit 1 -> -A.
        for (int k = 0; k < 8; k++) begin
            bi = pat[2*k];
            bq = pat[2*k+1];
            for (int s = 0; s < 4; s++) send(bi ? -1000 : 1000, bq ? -1000 : 1000, 1'b0);
        end
        idle(2);
        checks++;
        if (got_i.size() !== 8) begin
            failures++; $display("FAIL loop_count got=%0d exp=8", got_i.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({got_q[k], got_i[k]} !== pat[2*k +: 2]) begin
                failures++;
                $display("FAIL loop_pair k=%0d got QI=%b%b exp=%b",
                         k, got_q[k], got_i[k], pat[2*k +: 2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_extreme();
        test_backpressure();
        test_sync();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
